// File: rtl/mem_req_arbiter.sv
// Arbitrates the shared byte-serial memory-controller port between instruction
// fetch and the load/store unit; LS has priority, fetch has a starvation bound.
module mem_req_arbiter #(
   parameter int          STARVE_MAX = 4,
   parameter logic [31:0] IO_BASE    = 32'h0003_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        io_buffer_full,
   input  logic        flush,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_done,
   output logic [31:0] if_inst,
   input  logic        ls_req,
   input  logic        ls_we,
   input  logic [2:0]  ls_len,
   input  logic [31:0] ls_addr,
   input  logic [31:0] ls_wdata,
   output logic        ls_done,
   output logic [31:0] ls_rdata,
   output logic        mc_en,
   output logic        mc_we,
   output logic [2:0]  mc_len,
   output logic [31:0] mc_addr,
   output logic [31:0] mc_wdata,
   input  logic        mc_done,
   input  logic [31:0] mc_rdata,
   output logic [1:0]  owner
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_GRANT_IF,
      S_GRANT_LS,
      S_DRAIN,
      S_RESP
   } state_t;

   localparam logic [2:0] LP_STARVE_MAX = 3'(STARVE_MAX);
   localparam logic [1:0] LP_OWN_NONE   = 2'd0;
   localparam logic [1:0] LP_OWN_IF     = 2'd1;
   localparam logic [1:0] LP_OWN_LS     = 2'd2;

   state_t      r_state;
   state_t      w_next;
   logic [2:0]  r_starve;
   logic [1:0]  r_owner;
   logic        r_mc_en;
   logic        r_mc_we;
   logic [2:0]  r_mc_len;
   logic [31:0] r_mc_addr;
   logic [31:0] r_mc_wdata;
   logic [31:0] r_rdata;

   logic w_idle;
   logic w_ls_ok;
   logic w_grant_ls;
   logic w_grant_if;
   logic w_capture;

   // An IO access waits while the IO buffer is full; once granted it is never revoked.
   assign w_idle     = (r_state == S_IDLE);
   assign w_ls_ok    = ls_req & ~(io_buffer_full & (ls_addr >= IO_BASE));
   assign w_grant_ls = w_idle & w_ls_ok & (~if_req | flush | (r_starve < LP_STARVE_MAX));
   assign w_grant_if = w_idle & ~w_grant_ls & if_req & ~flush;
   assign w_capture  = mc_done & ((r_state == S_GRANT_LS) | ((r_state == S_GRANT_IF) & ~flush));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else if (rdy) begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_grant_ls)      w_next = S_GRANT_LS;
            else if (w_grant_if) w_next = S_GRANT_IF;
         end
         S_GRANT_IF: begin
            if (mc_done)    w_next = flush ? S_IDLE : S_RESP;
            else if (flush) w_next = S_DRAIN;
         end
         S_GRANT_LS: if (mc_done) w_next = S_RESP;
         S_DRAIN:    if (mc_done) w_next = S_IDLE;
         S_RESP:     w_next = S_IDLE;
         default:    w_next = S_IDLE;
      endcase
   end

   // Done pulses are suppressed while stalled so the RESP cycle replays intact.
   always_comb begin
      if_done = 1'b0;
      ls_done = 1'b0;
      if (rdy && r_state == S_RESP) begin
         if_done = (r_owner == LP_OWN_IF) & ~flush;
         ls_done = (r_owner == LP_OWN_LS);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_starve   <= 3'd0;
         r_owner    <= LP_OWN_NONE;
         r_mc_en    <= 1'b0;
         r_mc_we    <= 1'b0;
         r_mc_len   <= 3'd0;
         r_mc_addr  <= 32'd0;
         r_mc_wdata <= 32'd0;
         r_rdata    <= 32'd0;
      end else if (rdy) begin
         if (w_grant_ls) begin
            r_mc_en    <= 1'b1;
            r_mc_we    <= ls_we;
            r_mc_len   <= ls_len;
            r_mc_addr  <= ls_addr;
            r_mc_wdata <= ls_wdata;
            r_owner    <= LP_OWN_LS;
            if (!if_req)
               r_starve <= 3'd0;
            else if (r_starve != LP_STARVE_MAX)
               r_starve <= r_starve + 3'd1;
         end else if (w_grant_if) begin
            r_mc_en    <= 1'b1;
            r_mc_we    <= 1'b0;
            r_mc_len   <= 3'd4;
            r_mc_addr  <= if_addr;
            r_mc_wdata <= 32'd0;
            r_owner    <= LP_OWN_IF;
            r_starve   <= 3'd0;
         end
         if (!w_idle && r_state != S_RESP && mc_done)
            r_mc_en <= 1'b0;
         if (w_capture)
            r_rdata <= mc_rdata;
         if (!w_idle && w_next == S_IDLE)
            r_owner <= LP_OWN_NONE;
      end
   end

   assign mc_en    = r_mc_en;
   assign mc_we    = r_mc_we;
   assign mc_len   = r_mc_len;
   assign mc_addr  = r_mc_addr;
   assign mc_wdata = r_mc_wdata;
   assign if_inst  = r_rdata;
   assign ls_rdata = r_rdata;
   assign owner    = r_owner;

endmodule
